serial_in_fifo: RTL

SERIAL_IN_FIFO -- requirements
Module: serial_in_fifo

---
 rtl/serial_in_fifo.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/serial_in_fifo.sv
// -----------------------------------------------------------------------------
// serial_in_fifo
//
// Asynchronous serial receiver feeding a show-ahead receive FIFO. The serial
// line is synchronised, framed by a start/data/[parity]/stop state machine
// sampling at mid-bit, and each good character is written into the FIFO one
// cycle after its stop bit has been sampled.
//
// Optional feature macro: SERIAL_RX_PARITY_EN
//   defined   -> a parity bit follows the data bits and is checked against
//                PARITY_ODD (0 even, 1 odd); a mismatch pulses perr on the
//                push cycle but the character is still stored.
//   undefined -> no parity bit is expected and perr is constant 0.
//
// Ports
//   m_clock    in   1          single clock, rising edge
//   p_reset    in   1          synchronous reset, active low
//   rxd        in   1          asynchronous serial line, idle high
//   port_read  in   1          pop the FIFO head (ignored when empty)
//   data       out  DATA_BITS  FIFO head, zero when empty
//   rxready    out  1          FIFO not empty
//   done       out  1          one-cycle pulse when a character is stored
//   count      out  clog2(FIFO_DEPTH+1)  FIFO occupancy
//   ferr       out  1          one-cycle pulse on a framing error
//   perr       out  1          one-cycle pulse on a parity error
//   overrun    out  1          sticky: a character was dropped (FIFO full),
//                              cleared by the next accepted pop
// -----------------------------------------------------------------------------
module serial_in_fifo #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 16,
   parameter int PARITY_ODD   = 0
) (
   input  logic                             m_clock,
   input  logic                             p_reset,
   input  logic                             rxd,
   input  logic                             port_read,
   output logic [DATA_BITS-1:0]             data,
   output logic                             rxready,
   output logic                             done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
   output logic                             ferr,
   output logic                             perr,
   output logic                             overrun
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

   // Reject illegal configurations at elaboration time.
   if (DATA_BITS < 5 || DATA_BITS > 9 ||
       CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("serial_in_fifo: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef SERIAL_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_RECOVER
   } state_t;

   // ---------------------------------------------------------------- state
   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic                 prev_q, prev_d;       // previous synchronised level
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;         // cycles within current bit
   logic [IDX_W-1:0]     idx_q, idx_d;         // data bit index
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 push_pend_q, push_pend_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]     count_q, count_d;
   logic                 done_q, done_d;
   logic                 ferr_q, ferr_d;
   logic                 overrun_q, overrun_d;
`ifdef SERIAL_RX_PARITY_EN
   logic                 perr_pend_q, perr_pend_d;
   logic                 perr_q, perr_d;
`endif

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

   logic line_fall;
   logic pop_ok;
   logic push_ok;
   logic drop;

   // ---------------------------------------------------------------- receive FSM
   assign sync1_d   = rxd;
   assign sync2_d   = sync1_q;
   assign prev_d    = sync2_q;
   assign line_fall = prev_q & ~sync2_q;

   // NOTE: every always_comb output gets a default before the case so that no
   // path leaves it unassigned; a missing default would infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      idx_d       = idx_q;
      shift_d     = shift_q;
      push_pend_d = 1'b0;
      ferr_d      = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_pend_d = perr_pend_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (line_fall) state_d = S_START;
         end
         S_START: begin
            // Mid-start check: a line back high here was only a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = sync2_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};   // LSB first
               if (idx_q == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
`ifdef SERIAL_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               // XOR over data+parity is 1 when the total count of ones is odd.
               perr_pend_d = ((^shift_q) ^ sync2_q) != 1'(PARITY_ODD);
               state_d     = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (sync2_q) begin
                  push_pend_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_RECOVER;
               end
            end
         end
         S_RECOVER: begin
            // Stay deaf to falling edges until the line has returned high.
            cnt_d = '0;
            if (sync2_q) state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- FIFO control
   // A pop on an empty FIFO is ignored; a push into a full FIFO succeeds only
   // when a pop frees the head slot on the same edge.
   always_comb begin
      pop_ok    = port_read && (count_q != '0);
      push_ok   = push_pend_q && ((count_q != OCC_FULL) || pop_ok);
      drop      = push_pend_q && !push_ok;
      wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop_ok);
      count_d   = count_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
      done_d    = push_ok;
      overrun_d = overrun_q;
      if (pop_ok) overrun_d = 1'b0;
      if (drop)   overrun_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
      perr_d    = push_pend_q && perr_pend_q;
`endif
   end

   // ---------------------------------------------------------------- registers
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop regardless of order.
   always_ff @(posedge m_clock) begin
      if (!p_reset) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         prev_q      <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         push_pend_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
         ferr_q      <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         perr_pend_q <= 1'b0;
         perr_q      <= 1'b0;
`endif
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         prev_q      <= prev_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         push_pend_q <= push_pend_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         done_q      <= done_d;
         ferr_q      <= ferr_d;
         overrun_q   <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
         perr_pend_q <= perr_pend_d;
         perr_q      <= perr_d;
`endif
      end
   end

   // NOTE: the storage array has no reset; occupancy and pointers are reset,
   // and data is masked to zero while empty, so stale contents never escape.
   always_ff @(posedge m_clock) begin
      if (p_reset && push_ok) mem[wr_ptr_q] <= shift_q;
   end

   // ---------------------------------------------------------------- outputs
   assign data    = (count_q == '0) ? '0 : mem[rd_ptr_q];
   assign rxready = (count_q != '0);
   assign count   = count_q;
   assign done    = done_q;
   assign ferr    = ferr_q;
   assign overrun = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
   assign perr    = perr_q;
`else
   assign perr    = 1'b0;
`endif

endmodule
